// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and helpers for the pipeline stall/flush sequencer.
//   state_t  : sequencer states (RUN, LU_HOLD, MEM_WAIT)
//   REG_ZERO : index of the hard-wired zero register, never a real hazard
//   sat_inc  : increment that sticks at the all-ones value of a given width
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_HOLD  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int REG_ZERO = 0;

    // Counters of any width up to 32 bits are passed in zero-extended, so
    // the ceiling is computed from the width rather than from the operand.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned cnt_width);
        logic [31:0] max_val;
        max_val = (cnt_width >= 32) ? 32'hFFFF_FFFF
                                    : ((32'd1 << cnt_width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_lu_cmp.sv
// lu_cmp
// Load-use hazard detector between the load sitting in EX and the
// instruction being decoded in ID.
//   idex_memread : EX instruction is a load
//   idex_rt      : load destination register
//   ifid_rs      : ID source register rs
//   ifid_rt      : ID source register rt
//   ifid_uses_rt : ID instruction actually reads rt
//   lu           : stall is required this cycle
module lu_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    output logic             lu
);

    // A load into the zero register writes nothing, so it can never feed a
    // stale value forward; rt only counts when the decoded op reads it.
    assign lu = idex_memread
             && (idex_rt != REG_W'(REG_ZERO))
             && ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Stall/flush sequencer for the 5-stage core.
//   inputs : hazard sources (idex_*, ifid_*), branch_taken, dmem_req/ready
//   outputs: per-stage write enables (pc_we, ifid_we, idex_we, exmem_we),
//            ifid_flush / idex_bubble squash controls,
//            saturating perf counters (stall_cnt, flush_cnt, memwait_cnt),
//            sticky mem_err when a memory freeze lasts MEM_TIMEOUT cycles.
// Controls are combinational from state and inputs; state and counters are
// registered. Priority each cycle: memory freeze > branch > load-use.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W           = 5,
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 16,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
    output logic             mem_err
);

    localparam int         TMO_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] HOLD_INIT = 3'(LU_STALL_CYCLES - 1);

    state_t           state_q, state_d;
    state_t           saved_q, saved_d;
    logic [2:0]       hold_q, hold_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mem_err_d;
    logic             inc_stall, inc_flush, inc_memwait;
    logic             lu, freeze;
    state_t           eff_state;

    lu_cmp #(
        .REG_W(REG_W)
    ) u_lu_cmp (
        .idex_memread(idex_memread),
        .idex_rt     (idex_rt),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .ifid_uses_rt(ifid_uses_rt),
        .lu          (lu)
    );

    assign freeze    = dmem_req && !dmem_ready;
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    // Next-state and control decode. A released MEM_WAIT behaves exactly
    // like the state it interrupted, so decoding runs on eff_state and the
    // hold count is left untouched while frozen. During a branch ifid_we
    // stays high so IF/ID takes the flush NOP along with the rest of the
    // advancing pipe. Reset gates every control low at the end.
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        hold_d      = hold_q;
        tmo_d       = '0;
        mem_err_d   = mem_err;
        inc_stall   = 1'b0;
        inc_flush   = 1'b0;
        inc_memwait = 1'b0;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_bubble = 1'b0;
        exmem_we    = 1'b0;

        if (freeze) begin
            state_d     = MEM_WAIT;
            inc_memwait = 1'b1;
            if (state_q != MEM_WAIT) begin
                saved_d = state_q;
            end
            tmo_d = (int'(tmo_q) < MEM_TIMEOUT) ? tmo_q + TMO_W'(1) : tmo_q;
            if (int'(tmo_q) + 1 >= MEM_TIMEOUT) begin
                mem_err_d = 1'b1;
            end
        end else if (branch_taken) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_we     = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
            inc_flush   = 1'b1;
            state_d     = RUN;
        end else if (eff_state == LU_HOLD || lu) begin
            idex_we     = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
            inc_stall   = 1'b1;
            if (eff_state == LU_HOLD) begin
                hold_d  = hold_q - 3'd1;
                state_d = (hold_q <= 3'd1) ? RUN : LU_HOLD;
            end else if (LU_STALL_CYCLES > 1) begin
                hold_d  = HOLD_INIT;
                state_d = LU_HOLD;
            end else begin
                state_d = RUN;
            end
        end else begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            state_d  = RUN;
        end

        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b0;
            idex_we     = 1'b0;
            idex_bubble = 1'b0;
            exmem_we    = 1'b0;
        end
    end

    // State, hold/timeout counters and saturating perf counters. Reset
    // drops any pending hold or freeze and returns straight to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            hold_q      <= '0;
            tmo_q       <= '0;
            mem_err     <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            mem_err <= mem_err_d;
            if (inc_stall) begin
                stall_cnt <= CNT_W'(sat_inc(32'(stall_cnt), CNT_W));
            end
            if (inc_flush) begin
                flush_cnt <= CNT_W'(sat_inc(32'(flush_cnt), CNT_W));
            end
            if (inc_memwait) begin
                memwait_cnt <= CNT_W'(sat_inc(32'(memwait_cnt), CNT_W));
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
// Drives two sequencer instances with identical stimulus:
//   dut 0: LU_STALL_CYCLES=1, CNT_W=16, MEM_TIMEOUT=255
//   dut 1: LU_STALL_CYCLES=3, CNT_W=4,  MEM_TIMEOUT=4
// Each is compared against a bubble-count reference model every cycle.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rt = '0;
    logic [4:0] ifid_rs = '0;
    logic [4:0] ifid_rt = '0;
    logic       ifid_uses_rt = 1'b0;
    logic       branch_taken = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b0;

    logic        pc_we_a, ifid_we_a, ifid_flush_a, idex_we_a, idex_bubble_a, exmem_we_a, mem_err_a;
    logic [15:0] stall_cnt_a, flush_cnt_a, memwait_cnt_a;
    logic        pc_we_b, ifid_we_b, ifid_flush_b, idex_we_b, idex_bubble_b, exmem_we_b, mem_err_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b, memwait_cnt_b;

    int tests = 0;
    int fails = 0;

    int pL[2]   = '{1, 3};
    int pT[2]   = '{255, 4};
    int pMax[2] = '{65535, 15};

    int m_left[2];
    int m_stall[2];
    int m_flush[2];
    int m_mw[2];
    int m_tmo[2];
    int m_err[2];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .REG_W(5), .LU_STALL_CYCLES(1), .CNT_W(16), .MEM_TIMEOUT(255)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a),
        .idex_we(idex_we_a), .idex_bubble(idex_bubble_a), .exmem_we(exmem_we_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a),
        .memwait_cnt(memwait_cnt_a), .mem_err(mem_err_a)
    );

    pipe_stall_ctrl #(
        .REG_W(5), .LU_STALL_CYCLES(3), .CNT_W(4), .MEM_TIMEOUT(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b),
        .idex_we(idex_we_b), .idex_bubble(idex_bubble_b), .exmem_we(exmem_we_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b),
        .memwait_cnt(memwait_cnt_b), .mem_err(mem_err_b)
    );

    // Control bundle order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we}
    function automatic logic [5:0] obsCtrl(input int k);
        if (k == 0) return {pc_we_a, ifid_we_a, ifid_flush_a, idex_we_a, idex_bubble_a, exmem_we_a};
        return {pc_we_b, ifid_we_b, ifid_flush_b, idex_we_b, idex_bubble_b, exmem_we_b};
    endfunction

    function automatic logic [31:0] obsCnt(input int k, input int which);
        if (k == 0) begin
            case (which)
                0:       return 32'(stall_cnt_a);
                1:       return 32'(flush_cnt_a);
                default: return 32'(memwait_cnt_a);
            endcase
        end
        case (which)
            0:       return 32'(stall_cnt_b);
            1:       return 32'(flush_cnt_b);
            default: return 32'(memwait_cnt_b);
        endcase
    endfunction

    function automatic logic obsErr(input int k);
        return (k == 0) ? mem_err_a : mem_err_b;
    endfunction

    task automatic checkOne(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_left[k]  = 0;
            m_stall[k] = 0;
            m_flush[k] = 0;
            m_mw[k]    = 0;
            m_tmo[k]   = 0;
            m_err[k]   = 0;
        end
    endtask

    function automatic bit modelLu();
        return idex_memread && (idex_rt != 5'd0)
            && ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    endfunction

    // Compare controls for the current inputs and counters as they stand
    // before this cycle's edge, then advance the model one cycle.
    task automatic checkOutput(input int k);
        logic [5:0] exp_ctrl;
        bit frz;
        frz = dmem_req && !dmem_ready;
        if (frz)                              exp_ctrl = 6'b000000;
        else if (branch_taken)                exp_ctrl = 6'b111111;
        else if (m_left[k] > 0 || modelLu())  exp_ctrl = 6'b000111;
        else                                  exp_ctrl = 6'b110101;
        checkOne("ctrl", k, 32'(obsCtrl(k)), 32'(exp_ctrl));
        checkOne("stall_cnt", k, obsCnt(k, 0), 32'(m_stall[k]));
        checkOne("flush_cnt", k, obsCnt(k, 1), 32'(m_flush[k]));
        checkOne("memwait_cnt", k, obsCnt(k, 2), 32'(m_mw[k]));
        checkOne("mem_err", k, 32'(obsErr(k)), 32'(m_err[k]));

        if (frz) begin
            if (m_mw[k] < pMax[k]) m_mw[k]++;
            m_tmo[k]++;
            if (m_tmo[k] >= pT[k]) m_err[k] = 1;
        end else begin
            m_tmo[k] = 0;
            if (branch_taken) begin
                if (m_flush[k] < pMax[k]) m_flush[k]++;
                m_left[k] = 0;
            end else if (m_left[k] > 0 || modelLu()) begin
                if (m_stall[k] < pMax[k]) m_stall[k]++;
                if (m_left[k] > 0) m_left[k]--;
                else               m_left[k] = pL[k] - 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urt, input logic br,
                                 input logic req, input logic rdy);
        @(negedge clk);
        idex_memread = mr;
        idex_rt      = irt;
        ifid_rs      = rs;
        ifid_rt      = rt;
        ifid_uses_rt = urt;
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
        #1;
        for (int k = 0; k < 2; k++) checkOutput(k);
    endtask

    task automatic checkReset();
        for (int k = 0; k < 2; k++) begin
            checkOne("rst_ctrl", k, 32'(obsCtrl(k)), 32'd0);
            checkOne("rst_stall", k, obsCnt(k, 0), 32'd0);
            checkOne("rst_flush", k, obsCnt(k, 1), 32'd0);
            checkOne("rst_memwait", k, obsCnt(k, 2), 32'd0);
            checkOne("rst_err", k, 32'(obsErr(k)), 32'd0);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkReset();
        rst_n = 1'b1;

        idle();
        // Load-use on rs: one bubble on dut0, three on dut1
        applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        checkOne("lu_pc_we_back", 0, 32'(pc_we_a), 32'd1);
        checkOne("lu_stall_cnt", 0, 32'(stall_cnt_a), 32'd1);
        idle();
        idle();

        // Zero register and rt-not-read must not stall
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd8, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load-use through rt when rt is read
        applyStimulus(1'b1, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        // Branch in the middle of dut1's hold cancels it
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        // Branch and load-use together: branch wins
        applyStimulus(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOne("br_flush", 0, 32'(ifid_flush_a), 32'd1);
        idle();

        // Three-cycle memory freeze, then release
        repeat (3) applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOne("mw_cnt", 0, 32'(memwait_cnt_a), 32'd3);
        idle();

        // Freeze during a load-use hold resumes the hold afterwards
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) idle();

        // Six-cycle freeze: dut1 times out after four and stays in error
        repeat (6) applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        checkOne("tmo_sticky", 1, 32'(mem_err_b), 32'd1);
        checkOne("tmo_none", 0, 32'(mem_err_a), 32'd0);
        idle();

        // Reset during dut1's second bubble
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        checkReset();
        modelReset();
        @(negedge clk);
        #1;
        checkReset();
        rst_n = 1'b1;
        idle();
        checkOne("rst_pc_we", 1, 32'(pc_we_b), 32'd1);

        // Randomised traffic over a small register range to hit hazards
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                repeat (6) applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Pipeline stall/flush sequencer for the 5-stage core. It detects load-use hazards between ID/EX and IF/ID, handles taken-branch squashes, and freezes the whole pipe while the data memory handshake is pending. It drives the per-stage write enables and bubble/flush controls and keeps stall performance counters.

Parameters:
REG_W, 5, register index width
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 16, width of the performance counters (saturating)
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_err is set

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
idex_memread  in  1  instruction in EX is a load
idex_rt  in  REG_W  load destination register
ifid_rs  in  REG_W  ID source register rs
ifid_rt  in  REG_W  ID source register rt
ifid_uses_rt  in  1  ID instruction reads rt
branch_taken  in  1  EX resolved a taken branch/jump
dmem_req  in  1  MEM stage has an access outstanding
dmem_ready  in  1  data memory completes the access this cycle
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  clear IF/ID to NOP
idex_we  out  1  ID/EX write enable
idex_bubble  out  1  load NOP into ID/EX
exmem_we  out  1  EX/MEM and MEM/WB write enable
stall_cnt  out  CNT_W  load-use bubble cycles
flush_cnt  out  CNT_W  branch flush events
memwait_cnt  out  CNT_W  memory freeze cycles
mem_err  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT

Behaviour:
- Reset (rst_n low, async): state RUN, internal counters 0, all *_cnt 0, mem_err 0. While rst_n is low, all enables, ifid_flush and idex_bubble are forced to 0.
- Hazard term lu = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
- Outputs are combinational from the current state and inputs, so they apply in the same cycle. State and counters are registered.
- FSM states are RUN, LU_HOLD, MEM_WAIT. Per-cycle priority is memory freeze > branch > load-use.
- Freeze condition is dmem_req && !dmem_ready, in any state:
  - All write enables are 0; ifid_flush and idex_bubble are 0.
  - The next state is MEM_WAIT. The state being left is saved and resumed once the freeze ends.
  - memwait_cnt increments by 1 and the timeout counter increments.
  - When the timeout counter reaches MEM_TIMEOUT, mem_err is set and stays set. The FSM keeps waiting.
- MEM_WAIT with dmem_ready=1 (or dmem_req=0): this cycle is decoded exactly as the saved state would decode it. The timeout counter clears.
- Branch (branch_taken=1, no freeze), in RUN or LU_HOLD:
  - pc_we=1, ifid_flush=1, idex_bubble=1, idex_we=1, exmem_we=1.
  - flush_cnt increments and any pending LU_HOLD is cancelled; the next state is RUN.
- Load-use (lu=1, no branch, no freeze) in RUN:
  - pc_we=0, ifid_we=0, idex_bubble=1, idex_we=1, exmem_we=1. stall_cnt increments.
  - If LU_STALL_CYCLES>1, go to LU_HOLD with hold count LU_STALL_CYCLES-1.
- LU_HOLD: same outputs as the load-use case. The hold count decrements and stall_cnt increments each cycle. At hold count 1, the next state is RUN.
- RUN with no event: all write enables are 1; ifid_flush and idex_bubble are 0.
- All counters saturate at all-ones. There is no wrap-around.
- Reset asserted mid-stall or mid-freeze returns to RUN immediately and drops all stall state.

Decomposition:
- pipe_ctrl_pkg holds:
  - the state enum (RUN, LU_HOLD, MEM_WAIT);
  - localparam REG_ZERO;
  - the saturating-increment function.
- One natural combinational sub-module: lu_cmp, which computes lu from the register and read-flag inputs.
- pipe_stall_ctrl contains the FSM, the hold and timeout counters, and the perf counters.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5'd4, ifid_rs=5'd4 for 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1 for exactly 1 cycle; stall_cnt=1.
- Zero register and no false hazard: idex_rt=0, ifid_rs=0 -> no stall. Then idex_rt=8, ifid_rt=8, ifid_uses_rt=0 -> no stall.
- Branch overrides load-use: lu=1 and branch_taken=1 in the same cycle -> ifid_flush=1, pc_we=1; flush_cnt=1, stall_cnt=0.
- Memory freeze: dmem_req=1, dmem_ready=0 for 3 cycles -> all enables 0 for 3 cycles; memwait_cnt=3. dmem_ready=1 -> enables return to 1.
- Timeout: MEM_TIMEOUT=4, hold the freeze for 6 cycles -> mem_err rises after 4 cycles and stays 1 after release.
- Reset mid-hold: LU_STALL_CYCLES=3, pulse rst_n low during the 2nd bubble -> all outputs 0 while low; after release, state RUN, counters 0, pc_we=1.
